// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the three requesters and the register-file write arbiter.
// The master side is the requesters plus clear control; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 8
) ();
    logic              clr_start;
    logic [2:0]        req;
    logic [2:0]        addr0;
    logic [2:0]        addr1;
    logic [2:0]        addr2;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              we;
    logic [2:0]        Addr;
    logic [DATA_W-1:0] wData;
    logic [2:0]        ack;
    logic              busy;
    logic              clr_done;

    modport master (
        output clr_start, req, addr0, addr1, addr2, data0, data1, data2,
        input  we, Addr, wData, ack, busy, clr_done
    );

    modport slave (
        input  clr_start, req, addr0, addr1, addr2, data0, data1, data2,
        output we, Addr, wData, ack, busy, clr_done
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port, with an 8-entry clear sweep.
// Every output is a flop, so grants appear one cycle after the request is sampled.
module regfile_write_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_write_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic              we_q, we_d;
    logic [2:0]        addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              clr_done_q, clr_done_d;
    logic [2:0]        eligible;
    logic [1:0]        grant;

    // First set bit of elig scanning last+1, last+2, last (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
        logic [1:0] pick;
        int         idx;
        pick = 2'd0;
        for (int i = 3; i >= 1; i--) begin
            idx = (int'(last) + i) % 3;
            if (elig[idx]) pick = 2'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ack_d      = 3'b000;
        busy_d     = 1'b0;
        clr_done_d = 1'b0;
        // A requester acked this cycle is masked so it cannot win twice in a row.
        eligible   = bus.req & ~ack_q;
        grant      = rr_pick(eligible, last_q);

        case (state_q)
            S_IDLE: begin
                if (bus.clr_start) begin
                    state_d = S_CLEAR;
                    we_d    = 1'b1;
                    addr_d  = 3'd0;
                    wdata_d = '0;
                    busy_d  = 1'b1;
                    cnt_d   = 3'd1;
                end else if (eligible != 3'b000) begin
                    we_d   = 1'b1;
                    ack_d  = 3'b001 << grant;
                    last_d = grant;
                    case (grant)
                        2'd0:    begin addr_d = bus.addr0; wdata_d = bus.data0; end
                        2'd1:    begin addr_d = bus.addr1; wdata_d = bus.data1; end
                        default: begin addr_d = bus.addr2; wdata_d = bus.data2; end
                    endcase
                end
            end
            S_CLEAR: begin
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = '0;
                busy_d  = 1'b1;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = S_DONE;
            end
            S_DONE: begin
                clr_done_d = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            last_q     <= 2'd2;
            we_q       <= 1'b0;
            addr_q     <= 3'd0;
            wdata_q    <= '0;
            ack_q      <= 3'b000;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign bus.we       = we_q;
    assign bus.Addr     = addr_q;
    assign bus.wData    = wdata_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a queue/arithmetic output predictor checked
// every cycle, plus literal spot checks on both the DUT and the predictor.
module tb_regfile_write_arbiter;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [2:0] ack;
        logic       busy;
        logic       done;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   model_ok = 1'b0;

    regfile_write_arbiter_if #(.DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Predictor: a sweep is a precomputed queue of outputs; otherwise plain round robin.
    out_t       exp_o;
    out_t       sweep_q[$];
    int         m_last;
    logic [2:0] m_elig;
    int         m_k;

    always @(posedge clk) begin
        if (rst) begin
            exp_o    = '0;
            m_last   = 2;
            sweep_q.delete();
            model_ok = 1'b1;
        end else if (sweep_q.size() > 0) begin
            exp_o = sweep_q.pop_front();
        end else if (bus.clr_start) begin
            exp_o = '0;
            exp_o.we = 1'b1;
            exp_o.busy = 1'b1;
            for (int a = 1; a < 8; a++) begin
                out_t e;
                e = '0;
                e.we = 1'b1;
                e.addr = 3'(a);
                e.busy = 1'b1;
                sweep_q.push_back(e);
            end
            begin
                out_t e;
                e = '0;
                e.addr = 3'd7;
                e.done = 1'b1;
                sweep_q.push_back(e);
            end
        end else begin
            m_elig = bus.req & ~exp_o.ack;
            m_k = -1;
            for (int i = 1; i <= 3; i++)
                if (m_k < 0 && m_elig[(m_last + i) % 3]) m_k = (m_last + i) % 3;
            exp_o.busy = 1'b0;
            exp_o.done = 1'b0;
            if (m_k >= 0) begin
                exp_o.we  = 1'b1;
                exp_o.ack = 3'(1 << m_k);
                exp_o.addr  = (m_k == 0) ? bus.addr0 : (m_k == 1) ? bus.addr1 : bus.addr2;
                exp_o.wdata = (m_k == 0) ? bus.data0 : (m_k == 1) ? bus.data1 : bus.data2;
                m_last = m_k;
            end else begin
                exp_o.we  = 1'b0;
                exp_o.ack = 3'b000;
            end
        end
    end

    out_t got_o;
    always @(negedge clk) begin
        if (model_ok) begin
            got_o = {bus.we, bus.Addr, bus.wData, bus.ack, bus.busy, bus.clr_done};
            n_cmp++;
            if (got_o !== exp_o) begin
                n_bad++;
                $display("FAIL cycle_model t=%0t got we=%b Addr=%0d wData=%h ack=%b busy=%b done=%b required we=%b Addr=%0d wData=%h ack=%b busy=%b done=%b",
                         $time, got_o.we, got_o.addr, got_o.wdata, got_o.ack, got_o.busy, got_o.done,
                         exp_o.we, exp_o.addr, exp_o.wdata, exp_o.ack, exp_o.busy, exp_o.done);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0t got %h required %h", name, $time, got, want);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] ack_seq [6];

    initial begin
        bus.clr_start = 1'b0;
        bus.req = 3'b000;
        bus.addr0 = 3'd0; bus.addr1 = 3'd0; bus.addr2 = 3'd0;
        bus.data0 = '0;   bus.data1 = '0;   bus.data2 = '0;

        // Reset state and single request from requester 0.
        do_reset();
        chk("reset_out", {bus.we, bus.Addr, bus.wData, bus.ack, bus.busy, bus.clr_done}, 32'd0);
        bus.req = 3'b001; bus.addr0 = 3'd5; bus.data0 = 8'hA5;
        tick();
        bus.req = 3'b000;
        chk("single_grant", {bus.we, bus.Addr, bus.wData, bus.ack}, {1'b1, 3'd5, 8'hA5, 3'b001});
        chk("model_single_ack", exp_o.ack, 3'b001);
        tick();
        chk("single_release", {bus.we, bus.ack}, {1'b0, 3'b000});

        // All three requesting: strict rotation, one write per cycle.
        do_reset();
        bus.addr0 = 3'd1; bus.addr1 = 3'd2; bus.addr2 = 3'd3;
        bus.data0 = 8'h11; bus.data1 = 8'h22; bus.data2 = 8'h33;
        bus.req = 3'b111;
        ack_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr3_ack", bus.ack, ack_seq[i]);
            chk("rr3_we_addr", {bus.we, bus.Addr},
                {1'b1, (ack_seq[i] == 3'b001) ? 3'd1 : (ack_seq[i] == 3'b010) ? 3'd2 : 3'd3});
        end
        chk("model_rr3_ack", exp_o.ack, 3'b100);
        bus.req = 3'b000;
        tick();

        // Lone requester 1 is granted every other cycle.
        do_reset();
        bus.req = 3'b010;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lone_ack", bus.ack, (i % 2 == 0) ? 3'b010 : 3'b000);
            chk("lone_we", bus.we, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        bus.req = 3'b000;
        tick();
        tick();

        // Clear wins over a simultaneous request; the request is served after clr_done.
        bus.clr_start = 1'b1;
        bus.req = 3'b100; bus.addr2 = 3'd3; bus.data2 = 8'h3C;
        tick();
        bus.clr_start = 1'b0;
        for (int a = 0; a < 8; a++) begin
            if (a > 0) tick();
            chk("sweep_out", {bus.we, bus.Addr, bus.wData, bus.ack, bus.busy, bus.clr_done},
                {1'b1, 3'(a), 8'h00, 3'b000, 1'b1, 1'b0});
        end
        tick();
        chk("sweep_done", {bus.we, bus.ack, bus.busy, bus.clr_done}, {1'b0, 3'b000, 1'b0, 1'b1});
        chk("model_sweep_done", exp_o.done, 1'b1);
        tick();
        chk("after_sweep_grant", {bus.we, bus.Addr, bus.wData, bus.ack, bus.clr_done},
            {1'b1, 3'd3, 8'h3C, 3'b100, 1'b0});
        bus.req = 3'b000;
        tick();

        // Reset in the middle of a sweep aborts it without clr_done.
        do_reset();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_at3", {bus.Addr, bus.busy}, {3'd3, 1'b1});
        rst = 1'b1;
        tick();
        chk("abort_zero", {bus.we, bus.Addr, bus.wData, bus.ack, bus.busy, bus.clr_done}, 32'd0);
        rst = 1'b0;
        bus.addr0 = 3'd4; bus.addr1 = 3'd5; bus.addr2 = 3'd6;
        bus.req = 3'b111;
        tick();
        chk("abort_no_done", bus.clr_done, 1'b0);
        chk("abort_first_grant", {bus.ack, bus.Addr}, {3'b001, 3'd4});
        bus.req = 3'b000;
        tick();

        // Pointer check: after granting 1, req=101 goes to 2 and then 0.
        bus.req = 3'b010;
        tick();
        chk("ptr_grant1", bus.ack, 3'b010);
        bus.req = 3'b101;
        tick();
        chk("ptr_grant2", {bus.ack, bus.Addr}, {3'b100, 3'd6});
        bus.req = 3'b001;
        tick();
        chk("ptr_grant0", {bus.ack, bus.Addr}, {3'b001, 3'd4});
        bus.req = 3'b000;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
